// File: rtl/serial_nibble_rx.sv
// Framed serial receiver: start, 4 data bits (LSB = first), optional parity, stop -> 4-bit word on a..d.
// Latency: word/error pulses appear on the edge ending the stop-bit cycle (7 cycles per frame, 6 without parity).
// Backpressure: one-word valid/ready holding slot; a good word arriving while the slot is held and not draining is dropped with an overrun pulse.
module serial_nibble_rx #(
  parameter bit PARITY_EN = 1'b1,
  parameter bit ODD       = 1'b1
) (
  input  logic       clk,
  input  logic       areset_n,
  input  logic       in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    st_idle,
    st_data,
    st_parity,
    st_stop,
    st_wait
  } state_t;

  state_t     state;
  logic [1:0] bit_idx;
  logic [3:0] shreg;
  logic       par_bit;

  logic       parity_ok;
  logic       stop_cycle;
  logic       fe_set;
  logic       pe_set;
  logic       deliver;
  logic       load_word;
  logic       ov_set;
  logic       err_evt;
  logic       xfer;

  // Stop-cycle resolution: frame error outranks parity error; good words either load or overrun.
  always_comb begin
    parity_ok  = 1'b1;
    if (PARITY_EN) begin
      parity_ok = ((^shreg) ^ par_bit) == ODD;
    end
    stop_cycle = (state == st_stop);
    fe_set     = stop_cycle && !in;
    pe_set     = stop_cycle && in && !parity_ok;
    deliver    = stop_cycle && in && parity_ok;
    xfer       = out_valid && out_ready;
    load_word  = deliver && (!out_valid || out_ready);
    ov_set     = deliver && out_valid && !out_ready;
    err_evt    = fe_set || pe_set || ov_set;
  end

  // Frame FSM plus registered output slot, error pulses and saturating error counter.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state      <= st_idle;
      bit_idx    <= 2'd0;
      shreg      <= 4'd0;
      par_bit    <= 1'b0;
      out_valid  <= 1'b0;
      a          <= 1'b0;
      b          <= 1'b0;
      c          <= 1'b0;
      d          <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      // frame sequencing
      case (state)
        st_idle: begin
          if (!in) begin
            state   <= st_data;
            bit_idx <= 2'd0;
          end
        end
        st_data: begin
          shreg[bit_idx] <= in;
          bit_idx        <= bit_idx + 2'd1;
          if (bit_idx == 2'd3) begin
            state <= PARITY_EN ? st_parity : st_stop;
          end
        end
        st_parity: begin
          par_bit <= in;
          state   <= st_stop;
        end
        st_stop: begin
          // a low stop bit means we may be mid-garbage; wait for the line to idle
          state <= in ? st_idle : st_wait;
        end
        st_wait: begin
          if (in) begin
            state <= st_idle;
          end
        end
        default: state <= st_idle;
      endcase

      // output slot: load on delivery when free or draining, otherwise clear on transfer
      if (load_word) begin
        out_valid <= 1'b1;
        a         <= shreg[0];
        b         <= shreg[1];
        c         <= shreg[2];
        d         <= shreg[3];
      end else if (xfer) begin
        out_valid <= 1'b0;
      end

      // single-cycle error pulses
      frame_err  <= fe_set;
      parity_err <= pe_set;
      overrun    <= ov_set;

      // at most one error source fires per cycle, so +1 is enough
      if (err_evt && (err_count != 8'hff)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_serial_nibble_rx.sv
// Bench for serial_nibble_rx: constant-expectation frame table, hand corner sequences, random frames vs model.
// Latency: checks every output one time unit after each rising edge.
// Backpressure: out_ready driven per cycle (fixed per table row, or random).
module tb_serial_nibble_rx;

  localparam int EV_NONE = 0;
  localparam int EV_GOOD = 1;
  localparam int EV_PERR = 2;
  localparam int EV_FERR = 3;

  logic       clk = 1'b0;
  logic       areset_n;
  logic       in;
  logic       out_ready;
  logic       out_valid;
  logic       a, b, c, d;
  logic       frame_err, parity_err, overrun;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  // behavioural model of the output side
  logic       m_valid;
  logic [3:0] m_word;
  logic       m_fe, m_pe, m_ov;
  logic [7:0] m_cnt;
  bit         rdy_rand = 1'b0;

  serial_nibble_rx dut (
    .clk        (clk),
    .areset_n   (areset_n),
    .in         (in),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] dat;
    logic       par;
    logic       stp;
    logic       rdy_body;
    logic       rdy_stop;
    logic       exp_valid;
    logic [3:0] exp_word;
    logic       exp_fe;
    logic       exp_pe;
    logic       exp_ov;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [15:0] got_vec();
    return {out_valid, d, c, b, a, frame_err, parity_err, overrun, err_count};
  endfunction

  function automatic logic [15:0] exp_vec();
    return {m_valid, m_word, m_fe, m_pe, m_ov, m_cnt};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_word  = 4'd0;
    m_fe    = 1'b0;
    m_pe    = 1'b0;
    m_ov    = 1'b0;
    m_cnt   = 8'd0;
  endtask

  // one clock: drive inputs, advance model by the spec rules, compare
  task automatic drive_cycle(input logic in_v, input logic rdy_v, input int ev, input logic [3:0] w);
    logic rdy_eff;
    logic xfer;
    rdy_eff = rdy_rand ? ($urandom_range(0, 1) == 1) : rdy_v;
    @(negedge clk);
    in        = in_v;
    out_ready = rdy_eff;
    @(posedge clk);
    xfer = m_valid && rdy_eff;
    m_fe = 1'b0;
    m_pe = 1'b0;
    m_ov = 1'b0;
    if (ev == EV_GOOD) begin
      if (!m_valid || rdy_eff) begin
        m_word  = w;
        m_valid = 1'b1;
      end else begin
        m_ov = 1'b1;
      end
    end else if (xfer) begin
      m_valid = 1'b0;
    end
    if (ev == EV_PERR) m_pe = 1'b1;
    if (ev == EV_FERR) m_fe = 1'b1;
    if ((m_fe || m_pe || m_ov) && (m_cnt != 8'd255)) m_cnt = m_cnt + 8'd1;
    #1;
    check("cycle", got_vec(), exp_vec());
  endtask

  // full 7-cycle frame; outcome classified from odd parity and stop bit
  task automatic send_frame(input logic [3:0] dat, input logic par, input logic stp,
                            input logic rdy_body, input logic rdy_stop);
    int ev;
    if (!stp) ev = EV_FERR;
    else if (($countones({dat, par}) % 2) == 1) ev = EV_GOOD;
    else ev = EV_PERR;
    drive_cycle(1'b0, rdy_body, EV_NONE, 4'd0);
    for (int i = 0; i < 4; i++) drive_cycle(dat[i], rdy_body, EV_NONE, 4'd0);
    drive_cycle(par, rdy_body, EV_NONE, 4'd0);
    drive_cycle(stp, rdy_stop, ev, dat);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //                dat     par   stp   rb    rs    valid word    fe    pe    ov    cnt
    tbl[0] = '{4'b1101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1101, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1] = '{4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1101, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[2] = '{4'b0110, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[3] = '{4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b1, 1'b0, 8'd2};
    tbl[4] = '{4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0, 8'd3};
    tbl[5] = '{4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd3};
    tbl[6] = '{4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd4};
    tbl[7] = '{4'b1010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 8'd4};
    tbl[8] = '{4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, 8'd5};

    // reset state
    areset_n  = 1'b0;
    in        = 1'b1;
    out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", got_vec(), 16'h0000);
    @(negedge clk);
    areset_n = 1'b1;
    drive_cycle(1'b1, 1'b0, EV_NONE, 4'd0);

    // table of frames with hand-computed outcomes
    for (int i = 0; i < 9; i++) begin
      send_frame(tbl[i].dat, tbl[i].par, tbl[i].stp, tbl[i].rdy_body, tbl[i].rdy_stop);
      check($sformatf("table_%0d", i), got_vec(),
            {tbl[i].exp_valid, tbl[i].exp_word, tbl[i].exp_fe, tbl[i].exp_pe,
             tbl[i].exp_ov, tbl[i].exp_cnt});
      if (!tbl[i].stp) drive_cycle(1'b1, 1'b0, EV_NONE, 4'd0);
    end

    // handshake: one ready cycle drains the held word, data unchanged
    drive_cycle(1'b1, 1'b1, EV_NONE, 4'd0);
    check("handshake", {11'd0, out_valid, d, c, b, a}, {11'd0, 5'b0_1010});

    // stop error, line held low in WAIT, then recovery
    send_frame(4'b1101, 1'b0, 1'b0, 1'b0, 1'b0);
    check("stop_err_pulse", {15'd0, frame_err}, 16'd1);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, EV_NONE, 4'd0);
    check("wait_no_pulse", {13'd0, frame_err, parity_err, out_valid}, 16'd0);
    drive_cycle(1'b1, 1'b0, EV_NONE, 4'd0);
    send_frame(4'b0011, 1'b1, 1'b1, 1'b0, 1'b0);
    check("recovery", {11'd0, out_valid, d, c, b, a}, {11'd0, 5'b1_0011});

    // randomized frames, gaps and ready
    rdy_rand = 1'b1;
    for (int n = 0; n < 200; n++) begin
      logic [3:0] dat;
      logic       par;
      logic       stp;
      int         gap;
      dat = 4'($urandom);
      par = ~(^dat);
      if ($urandom_range(0, 3) == 0) par = ~par;
      stp = ($urandom_range(0, 6) != 0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) drive_cycle(1'b1, 1'b0, EV_NONE, 4'd0);
      send_frame(dat, par, stp, 1'b0, 1'b0);
      if (!stp) begin
        int z;
        z = $urandom_range(0, 3);
        for (int k = 0; k < z; k++) drive_cycle(1'b0, 1'b0, EV_NONE, 4'd0);
        drive_cycle(1'b1, 1'b0, EV_NONE, 4'd0);
      end
    end
    rdy_rand = 1'b0;

    // saturation
    for (int n = 0; n < 260; n++) send_frame(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
    check("saturate", {8'd0, err_count}, {8'd0, 8'd255});

    // asynchronous reset in the middle of a frame
    drive_cycle(1'b0, 1'b0, EV_NONE, 4'd0);
    drive_cycle(1'b1, 1'b0, EV_NONE, 4'd0);
    drive_cycle(1'b0, 1'b0, EV_NONE, 4'd0);
    #2;
    areset_n = 1'b0;
    #1;
    model_reset();
    check("reset_async", got_vec(), 16'h0000);
    in = 1'b1;
    @(negedge clk);
    areset_n = 1'b1;
    send_frame(4'b1001, 1'b1, 1'b1, 1'b0, 1'b0);
    check("after_reset", got_vec(), {1'b1, 4'b1001, 3'b000, 8'd0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_nibble_rx.md
# serial_nibble_rx

Serial frame receiver that sits directly upstream of the four-input `mod_a` stage. It deserializes a one-bit-per-clock framed stream into a 4-bit word, checks parity and stop bit, and presents the word on `a`, `b`, `c`, `d`. Words are handed over with a valid/ready handshake. Errors are reported as single-cycle pulses and counted in a saturating counter.

## Interface
- `PARITY_EN`, default 1: 1 = a parity bit follows the data bits; 0 = no parity bit, frame is one cycle shorter.
- `ODD`, default 1: 1 = odd parity (data bits plus parity bit contain an odd number of ones); 0 = even parity.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `areset_n`  in  1  asynchronous, active-low reset.
- `in`  in  1  serial line; idles high; one bit per clock.
- `out_ready`  in  1  downstream can accept the held word.
- `out_valid`  out  1  `a`..`d` hold a good word.
- `a`, `b`, `c`, `d`  out  1 each  data bits d0..d3 in arrival order (`a` = first data bit).
- `frame_err`  out  1  one-cycle pulse: the stop bit sampled 0.
- `parity_err`  out  1  one-cycle pulse: the parity check failed.
- `overrun`  out  1  one-cycle pulse: a good word was dropped because the output was occupied.
- `err_count`  out  8  saturating count of `frame_err`, `parity_err` and `overrun` events.

## Operation
- The frame is: start bit (0), d0, d1, d2, d3, parity bit (only when `PARITY_EN`=1), stop bit (1).
- The FSM has five states: IDLE, DATA, PARITY, STOP, WAIT.
- **IDLE:**
  - `in`=0 → DATA with the bit index cleared.
  - Otherwise stay in IDLE.
- **DATA:**
  - Shift `in` into the data register at the current index.
  - After the 4th bit → PARITY if `PARITY_EN`=1, else STOP.
- **PARITY:** capture `in` as the parity bit → STOP.
- **STOP**, resolved in priority order:
  - `in`=0 → pulse `frame_err`, discard the frame, go to WAIT. No parity check is made.
  - `in`=1 and parity bad → pulse `parity_err`, discard the frame, go to IDLE.
  - `in`=1 and parity good (or `PARITY_EN`=0) → deliver the word, go to IDLE.
- **WAIT:** stay until `in`=1, then go to IDLE. A 0 seen while in WAIT is never treated as a start bit.
- **Delivery** of a good word:
  - `out_valid`=0 → load the word into `a`..`d` and set `out_valid`.
  - `out_valid`=1 and `out_ready`=1 on the same edge → load the new word; `out_valid` stays 1.
  - `out_valid`=1 and `out_ready`=0 → pulse `overrun`; the held word is unchanged and the new word is dropped.
- **Handshake:**
  - A transfer happens on any edge where `out_valid`=1 and `out_ready`=1.
  - With no new word arriving, `out_valid` clears on that edge.
  - `a`..`d` are held stable while `out_valid`=1 and no transfer occurs.
  - `out_ready` is ignored while `out_valid`=0.
- **`err_count`:**
  - Increments by 1 on each error pulse.
  - At most one error event can occur per cycle.
  - Holds at 255; it never wraps.

## Timing
- **Reset** (asynchronous assert, on `areset_n`=0):
  - The FSM goes to IDLE and any partial frame is discarded.
  - All outputs go to 0: `out_valid`, `a`..`d`, `frame_err`, `parity_err`, `overrun`, `err_count`=0.
  - Deassertion is sampled on the next rising edge.
- **Frame length:** 7 cycles with `PARITY_EN`=1, 6 cycles with `PARITY_EN`=0.
- **Start bit:** sampled in IDLE in cycle t. Data bits are sampled in cycles t+1..t+4.
- **Stop bit:** sampled in cycle t+6 (t+5 when there is no parity bit).
- **Output timing:** `out_valid` and the error pulses become visible on the edge that ends the stop-bit cycle. Pulses last exactly one cycle.
- **Back-to-back frames:** a start bit in the cycle right after the stop bit is accepted. Sustained throughput is one word per 7 cycles.
- **Reset mid-frame** produces no error pulse and leaves `err_count`=0.

## Test plan
- **Good frame, default parameters:** drive `in` = 0, 1,0,1,1, 0, 1 with `out_ready`=0 → after the stop cycle: `out_valid`=1, `a`=1 `b`=0 `c`=1 `d`=1, no error pulses.
- **Handshake:** from the previous state, raise `out_ready` for one cycle → one transfer, `out_valid`=0 on the next cycle, `a`..`d` unchanged.
- **Parity error:** same frame with parity bit 1 → `parity_err` pulses once, `out_valid` stays 0, `err_count`=1.
- **Stop error and recovery:**
  - Frame with stop bit 0, then `in` held at 0 for 3 cycles → `frame_err` pulses once and the FSM stays in WAIT.
  - Then `in`=1 followed by a good frame → that frame is delivered.
- **Overrun:**
  - Two good back-to-back frames with `out_ready`=0 → `overrun` pulses at the end of the second frame and the first word is still held.
  - Repeat with `out_ready`=1 at the second stop edge → the second word is loaded and `out_valid` stays 1.
- **Saturation and reset:**
  - 260 parity-error frames → `err_count`=255.
  - Assert `areset_n`=0 in the middle of the next frame → all outputs 0 immediately.
  - The next good frame is received correctly.
